// File: rtl/mem_pkg.sv
// Shared definitions for the RAM arbitration slice: default bus widths and
// requester port indices.
package mem_pkg;

    localparam int ADDR_SIZE = 8;
    localparam int DATA_SIZE = 8;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    // Port that wins a two-way contention: whichever did not win last time.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input port_e last);
        logic [1:0] pick;
        pick = req;
        if (req == 2'b11) begin
            pick = (last == PORT_DATA) ? 2'b01 : 2'b10;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. It exposes the unconditional pick for
// hazard checks and the final grant, which is gated by allow.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       allow,
    output logic [1:0] pick,
    output logic [1:0] gnt
);

    port_e last_q;

    assign pick = rr_pick(req, last_q);
    assign gnt  = allow ? pick : 2'b00;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            last_q <= PORT_DATA;
        end else if (gnt != 2'b00) begin
            last_q <= port_e'(gnt[1]);
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one write port and one registered read port of a dual-port RAM
// between the fetch port (0) and the data port (1).
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int addr_size = ADDR_SIZE,
    parameter int data_size = DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0,
    input  logic                 we0,
    input  logic [addr_size-1:0] addr0,
    input  logic [data_size-1:0] wdata0,
    output logic                 gnt0,
    output logic                 rvalid0,
    output logic [data_size-1:0] rdata0,

    input  logic                 req1,
    input  logic                 we1,
    input  logic [addr_size-1:0] addr1,
    input  logic [data_size-1:0] wdata1,
    output logic                 gnt1,
    output logic                 rvalid1,
    output logic [data_size-1:0] rdata1,

    output logic                 ram_write_en,
    output logic [addr_size-1:0] ram_write_adress,
    output logic [data_size-1:0] ram_data_in,
    output logic                 ram_rd_en,
    output logic [addr_size-1:0] ram_rd_adress,
    input  logic [data_size-1:0] ram_data_out
);

    logic [1:0]           wr_req, rd_req;
    logic [1:0]           wr_pick, rd_pick;
    logic [1:0]           wr_gnt, rd_gnt;
    logic [addr_size-1:0] wr_addr, rd_addr;
    logic                 hazard;

    logic                 inflight_q;
    port_e                owner_q;
    logic [data_size-1:0] hold0_q, hold1_q;

    assign wr_req = {req1 &  we1, req0 &  we0};
    assign rd_req = {req1 & ~we1, req0 & ~we0};

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (wr_req),
        .allow (~rst),
        .pick  (wr_pick),
        .gnt   (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (rd_req),
        .allow (~rst & ~hazard),
        .pick  (rd_pick),
        .gnt   (rd_gnt)
    );

    assign wr_addr = wr_pick[1] ? addr1 : addr0;
    assign rd_addr = rd_pick[1] ? addr1 : addr0;

    // A read that would race a same-address write waits one cycle for the new data.
    assign hazard = (wr_pick != 2'b00) && (rd_pick != 2'b00) && (wr_addr == rd_addr);

    assign gnt0 = wr_gnt[0] | rd_gnt[0];
    assign gnt1 = wr_gnt[1] | rd_gnt[1];

    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latch is inferred.
        ram_write_en     = 1'b0;
        ram_write_adress = '0;
        ram_data_in      = '0;
        ram_rd_en        = 1'b0;
        ram_rd_adress    = '0;

        if (wr_gnt[1]) begin
            ram_write_en     = 1'b1;
            ram_write_adress = addr1;
            ram_data_in      = wdata1;
        end else if (wr_gnt[0]) begin
            ram_write_en     = 1'b1;
            ram_write_adress = addr0;
            ram_data_in      = wdata0;
        end

        if (rd_gnt[1]) begin
            ram_rd_en     = 1'b1;
            ram_rd_adress = addr1;
        end else if (rd_gnt[0]) begin
            ram_rd_en     = 1'b1;
            ram_rd_adress = addr0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            owner_q    <= PORT_FETCH;
            hold0_q    <= '0;
            hold1_q    <= '0;
        end else begin
            inflight_q <= (rd_gnt != 2'b00);
            if (rd_gnt != 2'b00) begin
                owner_q <= port_e'(rd_gnt[1]);
            end
            if (rvalid0) begin
                hold0_q <= ram_data_out;
            end
            if (rvalid1) begin
                hold1_q <= ram_data_out;
            end
        end
    end

    // RAM data is live only in the return cycle; otherwise each port keeps its last result.
    assign rvalid0 = inflight_q & (owner_q == PORT_FETCH);
    assign rvalid1 = inflight_q & (owner_q == PORT_DATA);
    assign rdata0  = rvalid0 ? ram_data_out : hold0_q;
    assign rdata1  = rvalid1 ? ram_data_out : hold1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a RAM model on the RAM side, a rule-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_ram_arbiter;
    import mem_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       ram_write_en, ram_rd_en;
    logic [7:0] ram_write_adress, ram_data_in, ram_rd_adress;
    logic [7:0] ram_data_out = '0;

    always #5 clk = ~clk;

    ram_arbiter #(.addr_size(8), .data_size(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_write_en(ram_write_en), .ram_write_adress(ram_write_adress),
        .ram_data_in(ram_data_in), .ram_rd_en(ram_rd_en),
        .ram_rd_adress(ram_rd_adress), .ram_data_out(ram_data_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input int i);
        return 8'(i) ^ 8'hC3;
    endfunction

    // RAM attached to the arbiter: synchronous write, registered read.
    logic [7:0] ram_mem [256];
    initial for (int i = 0; i < 256; i++) ram_mem[i] = init_val(i);
    always @(posedge clk) begin
        if (ram_rd_en) ram_data_out <= ram_mem[ram_rd_adress];
        if (ram_write_en) ram_mem[ram_write_adress] = ram_data_in;
    end

    // Reference model: arbitration rules applied to the sampled requests.
    bit         model_on = 1'b0;
    int         wr_last_m = 1, rd_last_m = 1;
    logic [7:0] gold [256];
    logic [1:0] exp_rv = 2'b00;
    logic [7:0] exp_rd [2];
    logic [7:0] hold_m [2];
    logic [1:0] m_rq, m_wq, m_gnt;
    logic [7:0] m_ad [2];
    logic [7:0] m_wd [2];
    logic [7:0] act_rdata [2];
    logic [1:0] act_rv, act_gnt;
    int         wwin, rwin;

    initial begin
        for (int i = 0; i < 256; i++) gold[i] = init_val(i);
        hold_m[0] = '0; hold_m[1] = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
    end

    function automatic int winner(input logic c0, input logic c1, input int last);
        if (c0 && c1) return 1 - last;
        if (c0) return 0;
        if (c1) return 1;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (model_on) begin
            m_rq = {req1 & ~we1, req0 & ~we0};
            m_wq = {req1 & we1, req0 & we0};
            m_ad[0] = addr0; m_ad[1] = addr1;
            m_wd[0] = wdata0; m_wd[1] = wdata1;
            wwin = winner(m_wq[0], m_wq[1], wr_last_m);
            rwin = winner(m_rq[0], m_rq[1], rd_last_m);
            if (rst) begin
                wwin = -1;
                rwin = -1;
            end else if (wwin >= 0 && rwin >= 0 && m_ad[wwin] == m_ad[rwin]) begin
                rwin = -1;
            end
            m_gnt = 2'b00;
            if (wwin >= 0) m_gnt[wwin] = 1'b1;
            if (rwin >= 0) m_gnt[rwin] = 1'b1;

            act_gnt = {gnt1, gnt0};
            act_rv  = {rvalid1, rvalid0};
            act_rdata[0] = rdata0; act_rdata[1] = rdata1;
            check("m_gnt", act_gnt, m_gnt);
            check("m_wen", ram_write_en, wwin >= 0);
            check("m_waddr", ram_write_adress, (wwin >= 0) ? m_ad[wwin] : 8'h00);
            check("m_wdata", ram_data_in, (wwin >= 0) ? m_wd[wwin] : 8'h00);
            check("m_ren", ram_rd_en, rwin >= 0);
            check("m_raddr", ram_rd_adress, (rwin >= 0) ? m_ad[rwin] : 8'h00);
            check("m_rvalid", act_rv, exp_rv);
            for (int p = 0; p < 2; p++) begin
                check($sformatf("m_rdata%0d", p), act_rdata[p], exp_rv[p] ? exp_rd[p] : hold_m[p]);
            end

            if (rst) begin
                wr_last_m = 1; rd_last_m = 1;
                exp_rv = 2'b00;
                hold_m[0] = '0; hold_m[1] = '0;
            end else begin
                for (int p = 0; p < 2; p++) if (exp_rv[p]) hold_m[p] = exp_rd[p];
                exp_rv = 2'b00;
                if (rwin >= 0) begin
                    exp_rv[rwin] = 1'b1;
                    exp_rd[rwin] = gold[m_ad[rwin]];
                    rd_last_m = rwin;
                end
                if (wwin >= 0) begin
                    gold[m_ad[wwin]] = m_wd[wwin];
                    wr_last_m = wwin;
                end
            end
        end
    end

    // Grant capture for the driver, plus the requester-stability protocol assertion.
    logic [1:0] g_seen = 2'b00, p_req = 2'b00, p_gnt = 2'b00, p_we = 2'b00;
    logic [7:0] p_addr [2];
    logic [7:0] p_wd [2];
    always @(negedge clk) begin
        if (p_req[0] && !p_gnt[0] && req0)
            assert (we0 == p_we[0] && addr0 == p_addr[0] && wdata0 == p_wd[0])
            else $error("port 0 request changed while waiting");
        if (p_req[1] && !p_gnt[1] && req1)
            assert (we1 == p_we[1] && addr1 == p_addr[1] && wdata1 == p_wd[1])
            else $error("port 1 request changed while waiting");
        g_seen = {gnt1, gnt0};
        p_req = {req1, req0};
        p_gnt = {gnt1, gnt0};
        p_we = {we1, we0};
        p_addr[0] = addr0; p_addr[1] = addr1;
        p_wd[0] = wdata0; p_wd[1] = wdata1;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (g_seen[0]) req0 = 1'b0;
        if (g_seen[1]) req1 = 1'b0;
    endtask

    task automatic issue(input int port, input logic we, input logic [7:0] a, input logic [7:0] d);
        if (port == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        model_on = 1'b1;

        // Request during reset is ignored.
        issue(0, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_rd_en", ram_rd_en, 1'b0);
        check("rst_rvalid0", rvalid0, 1'b0);
        check("rst_rdata0", rdata0, 8'h00);
        step();
        req0 = 1'b0; rst = 1'b0;

        // Single read by port 0.
        issue(0, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        check("t1_gnt0", gnt0, 1'b1);
        check("t1_gnt1", gnt1, 1'b0);
        step();
        @(negedge clk);
        check("t1_rvalid0", rvalid0, 1'b1);
        check("t1_rdata0", rdata0, 8'hD3);
        check("t1_rvalid1", rvalid1, 1'b0);
        step();

        // Concurrent write (port 0) and read (port 1) at different addresses.
        issue(0, 1'b1, 8'h20, 8'hAA);
        issue(1, 1'b0, 8'h30, 8'h00);
        @(negedge clk);
        check("t2_gnt0", gnt0, 1'b1);
        check("t2_gnt1", gnt1, 1'b1);
        step();
        @(negedge clk);
        check("t2_rvalid1", rvalid1, 1'b1);
        check("t2_rdata1", rdata1, 8'hF3);
        check("t2_rdata0_hold", rdata0, 8'hD3);
        check("t2_mem20", ram_mem[8'h20], 8'hAA);
        step();

        // Same-address hazard: write first, read stalls one cycle and sees new data.
        issue(1, 1'b1, 8'h40, 8'h55);
        issue(0, 1'b0, 8'h40, 8'h00);
        @(negedge clk);
        check("t3_gnt1", gnt1, 1'b1);
        check("t3_gnt0_stall", gnt0, 1'b0);
        step();
        @(negedge clk);
        check("t3_gnt0_late", gnt0, 1'b1);
        step();
        @(negedge clk);
        check("t3_rvalid0", rvalid0, 1'b1);
        check("t3_rdata0", rdata0, 8'h55);
        step();

        // Continuous two-way read contention alternates 0,1,0,1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (!req0) issue(0, 1'b0, 8'h01, 8'h00);
            if (!req1) issue(1, 1'b0, 8'h02, 8'h00);
            @(negedge clk);
            check($sformatf("t4_gnt0_%0d", i), gnt0, (i % 2) == 0);
            check($sformatf("t4_gnt1_%0d", i), gnt1, (i % 2) == 1);
            check($sformatf("t4_rv0_%0d", i), rvalid0, (i % 2) == 1);
            check($sformatf("t4_rv1_%0d", i), rvalid1, i == 2);
            if (rvalid0) check($sformatf("t4_rd0_%0d", i), rdata0, 8'hC2);
            if (rvalid1) check($sformatf("t4_rd1_%0d", i), rdata1, 8'hC1);
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("t4_rv1_last", rvalid1, 1'b1);
        check("t4_rd1_last", rdata1, 8'hC1);
        step();

        // Two writers right after reset: port 0 first, then port 1.
        do_reset();
        issue(0, 1'b1, 8'h60, 8'h11);
        issue(1, 1'b1, 8'h61, 8'h22);
        @(negedge clk);
        check("t5_gnt0", gnt0, 1'b1);
        check("t5_gnt1", gnt1, 1'b0);
        step();
        @(negedge clk);
        check("t5_gnt1_next", gnt1, 1'b1);
        check("t5_gnt0_next", gnt0, 1'b0);
        step();
        @(negedge clk);
        check("t5_mem60", ram_mem[8'h60], 8'h11);
        check("t5_mem61", ram_mem[8'h61], 8'h22);
        step();

        // Reset mid-operation: read pointer favours port 1, reset restores port 0 priority.
        issue(0, 1'b0, 8'h72, 8'h00);
        @(negedge clk);
        check("t6_gnt0_pre", gnt0, 1'b1);
        step();
        rst = 1'b1;
        issue(1, 1'b0, 8'h70, 8'h00);
        @(negedge clk);
        check("t6_rst_gnt1", gnt1, 1'b0);
        check("t6_rst_rden", ram_rd_en, 1'b0);
        check("t6_rst_wen", ram_write_en, 1'b0);
        step();
        @(negedge clk);
        check("t6_rst_rvalid1", rvalid1, 1'b0);
        check("t6_rst_rdata0", rdata0, 8'h00);
        step();
        rst = 1'b0;
        issue(0, 1'b0, 8'h71, 8'h00);
        @(negedge clk);
        check("t6_gnt0_first", gnt0, 1'b1);
        check("t6_gnt1_wait", gnt1, 1'b0);
        step();
        @(negedge clk);
        check("t6_gnt1", gnt1, 1'b1);
        check("t6_rvalid0", rvalid0, 1'b1);
        check("t6_rdata0", rdata0, 8'hB2);
        step();
        @(negedge clk);
        check("t6_rvalid1", rvalid1, 1'b1);
        check("t6_rdata1", rdata1, 8'hB3);
        step();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-clock dual-port RAM (one write port, one registered read port with 1-cycle latency) between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Per cycle it grants up to one write and one read to different requesters. It returns read data to the owning requester, and resolves same-address read/write hazards so reads always see the latest write.
- Sits between the CPU control unit and the RAM instance.

Parameters:
- addr_size, 8, address width of RAM and requesters
- data_size, 8, data width of RAM and requesters

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0  in  1  port 0 request; held until gnt0
- we0  in  1  port 0: 1=write, 0=read; stable while req0
- addr0  in  addr_size  port 0 address; stable while req0
- wdata0  in  data_size  port 0 write data; stable while req0
- gnt0  out  1  port 0 request accepted this cycle (combinational)
- rvalid0  out  1  port 0 read data valid (registered)
- rdata0  out  data_size  port 0 read data, meaningful only with rvalid0
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as port 0, for port 1
- ram_write_en  out  1  to RAM write_en
- ram_write_adress  out  addr_size  to RAM write address
- ram_data_in  out  data_size  to RAM data_in
- ram_rd_en  out  1  to RAM rd_en
- ram_rd_adress  out  addr_size  to RAM read address
- ram_data_out  in  data_size  from RAM data_out (valid the cycle after ram_rd_en)

Behaviour:
- Grant logic is combinational from req/we/addr and the registered pointers. All RAM-side outputs are derived from the granted request in the same cycle. The RAM samples on the next clk edge.
- Write arbitration:
  - Requesters with req=1, we=1 compete.
  - One contender: it wins.
  - Two contenders: the registered pointer wr_last decides; the port not equal to wr_last wins.
  - wr_last updates to the winner on every write grant.
- Read arbitration:
  - Requesters with req=1, we=0 compete, using a separate pointer rd_last with the same rule.
- Only one write or one read can be granted to a given port in a cycle, because each port holds a single request.
- Hazard rule:
  - Applies when a write and a read are both grantable in a cycle and the two addresses are equal.
  - Grant the write; withhold the read grant that cycle.
  - The read is granted the next cycle (its req is still held) and returns the new data.
- Read return:
  - A registered owner bit plus in-flight flag are set on each read grant.
  - Next cycle: rvalidN=1 for the owner only; rdataN = ram_data_out. The non-owner rdata holds its last value.
  - rvalid is a 1-cycle pulse per grant.
  - Back-to-back reads give one result per cycle.
- Write completion: the write is done at the grant edge. A read granted the following cycle at the same address returns the written data.
- Idle: when no grant, ram_write_en=0 and ram_rd_en=0. Address/data outputs carry don't-care values but are driven 0 for determinism.
- Reset:
  - While rst=1: no grants, ram_write_en=0, ram_rd_en=0.
  - Pointers reset: wr_last=1, rd_last=1, so port 0 wins the first contention.
  - rvalid0/1=0 and rdata0/1=0; the in-flight flag is cleared.
- Reset mid-operation: a read granted in the cycle rst asserts produces no rvalid. rst has priority over all updates.
- Requester rules: dropping req before gnt is allowed (the request is abandoned). Changing we/addr/wdata while req=1 without gnt is illegal (assertion in bench).
- Fairness: each pointer alternates under continuous two-way contention. Maximum wait is 1 cycle per class, plus 1 for the hazard stall.

Decomposition:
- Shared package (mem_pkg): ADDR_SIZE/DATA_SIZE defaults, and port index constants PORT_FETCH=0, PORT_DATA=1.
- One natural sub-module: rr_arb2, a 2-requester round-robin arbiter (req[1:0], last pointer register, gnt one-hot). Instantiated twice, once for writes and once for reads.
- Hazard check and read-return tracking stay in the top.

Test Plan:
- After reset, req0 read addr 0x10 only -> gnt0 in that cycle; rvalid0=1 with rdata0=mem[0x10] next cycle; rvalid1=0.
- req0 write 0x20<-0xAA and req1 read 0x30 in the same cycle -> gnt0=gnt1=1; RAM written; rvalid1 next cycle with mem[0x30].
- req1 write 0x40<-0x55 and req0 read 0x40 in the same cycle -> gnt1 only; gnt0 the next cycle; rvalid0 the cycle after with rdata0=0x55.
- Both ports read continuously for 4 cycles (0x01 vs 0x02) -> grants go 0,1,0,1; each rvalid matches its owner and address.
- Both write the same cycle first after reset -> port 0 wins; port 1 wins the next cycle; final mem reflects both writes.
- rst asserted in the cycle of a read grant to port 1 -> no rvalid1; all RAM enables 0 while rst=1; after release, port 0 wins the first contention.
